// File: rtl/framebuffer_scanout_if.sv
// framebuffer_scanout_if: framebuffer read port plus the aligned video output stream
interface framebuffer_scanout_if #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 8
);
  logic                  en_rd;
  logic [ADDR_WIDTH-1:0] addr_rd;
  logic [DATA_WIDTH-1:0] dout;
  logic                  hsync;
  logic                  vsync;
  logic                  pixel_de;
  logic [DATA_WIDTH-1:0] pixel;
  logic                  frame_start;
  modport master (output en_rd, addr_rd, hsync, vsync, pixel_de, pixel, frame_start, input dout);
  modport slave  (input en_rd, addr_rd, hsync, vsync, pixel_de, pixel, frame_start, output dout);
endinterface

// File: rtl/framebuffer_scanout.sv
// framebuffer_scanout: raster timing and scaled framebuffer fetch; every output is registered
// three cycles after the raster counters, so video flags and pixel data stay aligned.
module framebuffer_scanout #(
  parameter int FRAME_WIDTH    = 160,
  parameter int FRAME_HEIGHT   = 120,
  parameter int SCALING_FACTOR = 4,
  parameter int ADDR_WIDTH     = 15,
  parameter int DATA_WIDTH     = 8,
  parameter int H_FP           = 16,
  parameter int H_SYNC         = 96,
  parameter int H_BP           = 48,
  parameter int V_FP           = 10,
  parameter int V_SYNC         = 2,
  parameter int V_BP           = 33,
  parameter bit SYNC_POL       = 1'b0
) (
  input logic clk,
  input logic rst_n,
  input logic en,
  input logic rst_busy,
  framebuffer_scanout_if.master bus
);
  localparam int H_ACT = FRAME_WIDTH * SCALING_FACTOR;
  localparam int V_ACT = FRAME_HEIGHT * SCALING_FACTOR;
  localparam int H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOT);
  localparam int VW = $clog2(V_TOT);
  localparam int SW = SCALING_FACTOR > 1 ? $clog2(SCALING_FACTOR) : 1;
  localparam logic [HW-1:0] H_ACT_C = HW'(H_ACT);
  localparam logic [HW-1:0] H_SS = HW'(H_ACT + H_FP);
  localparam logic [HW-1:0] H_SL = HW'(H_ACT + H_FP + H_SYNC - 1);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
  localparam logic [VW-1:0] V_ACT_C = VW'(V_ACT);
  localparam logic [VW-1:0] V_SS = VW'(V_ACT + V_FP);
  localparam logic [VW-1:0] V_SL = VW'(V_ACT + V_FP + V_SYNC - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
  localparam logic [SW-1:0] S_LAST = SW'(SCALING_FACTOR - 1);
  localparam logic [ADDR_WIDTH-1:0] FW = ADDR_WIDTH'(FRAME_WIDTH);
  localparam logic [3:0] IDLE = {1'b0, ~SYNC_POL, ~SYNC_POL, 1'b0};
  if (SCALING_FACTOR < 1 || FRAME_WIDTH * FRAME_HEIGHT > 2 ** ADDR_WIDTH) begin : g_param_check
    $error("framebuffer_scanout: SCALING_FACTOR < 1 or frame does not fit ADDR_WIDTH");
  end
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic [SW-1:0] x_sub, y_sub;
  logic [ADDR_WIDTH-1:0] col, row_base;
  logic h_end, v_end, h_act, act, rd, rd2;
  logic [3:0] st0, st1, st2;
  // st vectors carry {de, hsync, vsync, frame_start} down the fetch pipeline
  always_comb begin
    h_end = h_cnt == H_LAST;
    v_end = v_cnt == V_LAST;
    h_act = h_cnt < H_ACT_C;
    act = en && h_act && v_cnt < V_ACT_C;
    rd = act && !rst_busy;
    st0 = {act,
           en && h_cnt >= H_SS && h_cnt <= H_SL ? SYNC_POL : ~SYNC_POL,
           en && v_cnt >= V_SS && v_cnt <= V_SL ? SYNC_POL : ~SYNC_POL,
           en && h_cnt == '0 && v_cnt == '0};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      {h_cnt, v_cnt, x_sub, y_sub, col, row_base} <= '0;
    end else if (!en) begin
      {h_cnt, v_cnt, x_sub, y_sub, col, row_base} <= '0;
    end else begin
      h_cnt <= h_end ? '0 : h_cnt + HW'(1);
      if (h_end) v_cnt <= v_end ? '0 : v_cnt + VW'(1);
      if (h_end) begin
        x_sub <= '0;
        col <= '0;
      end else if (h_act) begin
        x_sub <= x_sub == S_LAST ? '0 : x_sub + SW'(1);
        if (x_sub == S_LAST) col <= col + ADDR_WIDTH'(1);
      end
      if (h_end && v_end) begin
        y_sub <= '0;
        row_base <= '0;
      end else if (h_end && v_cnt < V_ACT_C) begin
        y_sub <= y_sub == S_LAST ? '0 : y_sub + SW'(1);
        if (y_sub == S_LAST) row_base <= row_base + FW;
      end
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.en_rd <= 1'b0;
      bus.addr_rd <= '0;
      rd2 <= 1'b0;
      st1 <= IDLE;
      st2 <= IDLE;
      {bus.pixel_de, bus.hsync, bus.vsync, bus.frame_start} <= IDLE;
      bus.pixel <= '0;
    end else begin
      bus.en_rd <= rd;
      if (rd) bus.addr_rd <= row_base + col;
      rd2 <= bus.en_rd;
      st1 <= st0;
      st2 <= st1;
      {bus.pixel_de, bus.hsync, bus.vsync, bus.frame_start} <= st2;
      bus.pixel <= rd2 ? bus.dout : '0;
    end
endmodule
